// File: rtl/mem_arbiter.sv
// Two-requester arbiter multiplexing instruction fetch and load/store traffic onto one memory port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch port
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_type,
  input  logic                  d_sign_ext,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // memory port
  output logic                  m_req,
  output logic                  m_we,
  output logic [1:0]            m_type,
  output logic                  m_sign_ext,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_gnt,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam logic [1:0] TYPE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  owner_data_q;  // 1: load/store owns the transaction, 0: fetch
  logic                  m_req_q;
  logic                  m_we_q;
  logic [1:0]            m_type_q;
  logic                  m_sign_ext_q;
  logic [DATA_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;

  logic                  grant;
  logic                  pick_data;
  logic                  resp;
  logic                  m_we_d;
  logic [1:0]            m_type_d;
  logic                  m_sign_ext_d;
  logic [DATA_WIDTH-1:0] m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_d;

`ifdef ARB_RR_EN
  logic last_data_q;

  // On contention the side that did not win the previous grant goes first.
  assign pick_data = d_req & (~if_req | ~last_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_q <= 1'b0;
    end else if (grant) begin
      last_data_q <= pick_data;
    end
  end
`else
  assign pick_data = d_req;
`endif

  // NOTE: grant is qualified with rst_n so a requester is never told it was
  // accepted while the FSM is held in reset and cannot capture the request.
  assign grant  = rst_n & (state_q == IDLE) & (if_req | d_req);
  assign d_gnt  = grant & pick_data;
  assign if_gnt = grant & ~pick_data;

  // Responses are only honoured in WAIT; anything else is stale or spurious.
  assign resp      = (state_q == WAIT) & m_rvalid;
  assign d_rvalid  = resp & owner_data_q;
  assign if_rvalid = resp & ~owner_data_q;
  assign d_rdata   = d_rvalid  ? m_rdata : '0;
  assign if_rdata  = if_rvalid ? m_rdata : '0;

  // Fetch is always a plain word load.
  assign m_we_d       = pick_data ? d_we       : 1'b0;
  assign m_type_d     = pick_data ? d_type     : TYPE_WORD;
  assign m_sign_ext_d = pick_data ? d_sign_ext : 1'b0;
  assign m_addr_d     = pick_data ? d_addr     : if_addr;
  assign m_wdata_d    = pick_data ? d_wdata    : '0;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_type_q     <= 2'b00;
      m_sign_ext_q <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q      <= ISSUE;
            owner_data_q <= pick_data;
            m_req_q      <= 1'b1;
            m_we_q       <= m_we_d;
            m_type_q     <= m_type_d;
            m_sign_ext_q <= m_sign_ext_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
          end
        end
        ISSUE: begin
          if (m_gnt) begin
            state_q <= WAIT;
            m_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_type     = m_type_q;
  assign m_sign_ext = m_sign_ext_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int         DW        = 32;
  localparam logic [1:0] TYPE_WORD = 2'b10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [DW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_sign_ext = 1'b0;
  logic [1:0]    d_type = 2'b00;
  logic [DW-1:0] d_addr = '0, d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we, m_sign_ext;
  logic [1:0]    m_type;
  logic [DW-1:0] m_addr, m_wdata;
  logic          m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  mem_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_sign_ext(d_sign_ext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_type(m_type), .m_sign_ext(m_sign_ext),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, tracked as "in flight" and
  // "accepted by memory", with the fields captured from the winning requester.
  bit          busy = 0, accepted = 0, own_data = 0, last_data = 0;
  bit          e_we = 0, e_sign = 0;
  logic [1:0]  e_type = '0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  bit          win_valid = 0, win_data = 0, resp = 0;

  function automatic bit data_wins();
`ifdef ARB_RR_EN
    return d_req && (!if_req || !last_data);
`else
    return d_req;
`endif
  endfunction

  task automatic sample();
    @(negedge clk);
    win_valid = !busy && (if_req || d_req);
    win_data  = win_valid && data_wins();
    resp      = busy && accepted && m_rvalid;
    check("if_gnt",    32'(if_gnt),    32'(win_valid && !win_data));
    check("d_gnt",     32'(d_gnt),     32'(win_data));
    check("m_req",     32'(m_req),     32'(busy && !accepted));
    check("if_rvalid", 32'(if_rvalid), 32'(resp && !own_data));
    check("d_rvalid",  32'(d_rvalid),  32'(resp && own_data));
    if (resp && !own_data) check("if_rdata", if_rdata, m_rdata);
    if (resp && own_data && !e_we) check("d_rdata", d_rdata, m_rdata);
    if (busy) begin
      check("m_addr",     m_addr,           e_addr);
      check("m_we",       32'(m_we),        32'(e_we));
      check("m_type",     32'(m_type),      32'(e_type));
      check("m_sign_ext", 32'(m_sign_ext),  32'(e_sign));
      if (e_we) check("m_wdata", m_wdata, e_wdata);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (win_valid) begin
      busy = 1; accepted = 0; own_data = win_data; last_data = win_data;
      if (win_data) begin
        e_we = d_we; e_type = d_type; e_sign = d_sign_ext; e_addr = d_addr; e_wdata = d_wdata;
      end else begin
        e_we = 0; e_type = TYPE_WORD; e_sign = 0; e_addr = if_addr; e_wdata = '0;
      end
    end else if (busy && !accepted && m_gnt) begin
      accepted = 1;
    end else if (resp) begin
      busy = 0;
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 0; d_req = 0;
    busy = 0; accepted = 0; own_data = 0; last_data = 0;
    #1;
    check("rst_if_gnt",    32'(if_gnt),    32'd0);
    check("rst_d_gnt",     32'(d_gnt),     32'd0);
    check("rst_m_req",     32'(m_req),     32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    check("rst_m_addr",    m_addr,         32'd0);
    check("rst_m_wdata",   m_wdata,        32'd0);
    check("rst_m_ctrl",    32'({m_we, m_type, m_sign_ext}), 32'd0);
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          grants;
    logic [3:0]  seq;
    logic [3:0]  seq_exp;
    #2;
    do_reset();

    // Single fetch, minimum turnaround.
    if_req = 1; if_addr = 32'h100;
    sample(); check("t1_if_gnt_c0", 32'(if_gnt), 32'd1); advance();
    if_req = 0; if_addr = '0; m_gnt = 1;
    sample();
    check("t1_m_addr", m_addr, 32'h100);
    check("t1_m_we", 32'(m_we), 32'd0);
    check("t1_m_type", 32'(m_type), 32'(TYPE_WORD));
    advance();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    sample();
    check("t1_if_rvalid_c2", 32'(if_rvalid), 32'd1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_d_rvalid", 32'(d_rvalid), 32'd0);
    advance();
    m_rvalid = 0;
    tick();

    // Store with a three-cycle memory stall.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_type = TYPE_WORD; d_sign_ext = 0;
    sample(); check("t2_d_gnt", 32'(d_gnt), 32'd1); advance();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_type = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t2_m_req_stall", 32'(m_req), 32'd1);
      check("t2_m_addr", m_addr, 32'h40);
      check("t2_m_wdata", m_wdata, 32'h12345678);
      check("t2_m_we", 32'(m_we), 32'd1);
      advance();
    end
    m_gnt = 1; tick();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hFFFF0000;
    sample(); check("t2_d_rvalid", 32'(d_rvalid), 32'd1); advance();
    m_rvalid = 0;
    tick();

    // Spurious responses in IDLE and ISSUE.
    m_rvalid = 1;
    sample(); check("t3_idle_if_rv", 32'(if_rvalid), 32'd0); check("t3_idle_d_rv", 32'(d_rvalid), 32'd0); advance();
    m_rvalid = 0; if_req = 1; if_addr = 32'h200;
    tick();
    if_req = 0; m_rvalid = 1;
    sample(); check("t3_issue_if_rv", 32'(if_rvalid), 32'd0); advance();
    m_rvalid = 0;
    sample(); check("t3_m_req_held", 32'(m_req), 32'd1); advance();
    m_gnt = 1; tick();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hA5A5A5A5;
    sample(); check("t3_if_rvalid", 32'(if_rvalid), 32'd1); advance();
    m_rvalid = 0;
    tick();

    // Reset while waiting for the memory response.
    if_req = 1; if_addr = 32'h300;
    tick();
    if_req = 0; m_gnt = 1;
    tick();
    m_gnt = 0; m_rvalid = 1;
    do_reset();
    m_rvalid = 1; m_rdata = 32'h0BADF00D;
    sample(); check("t4_late_rv", 32'(if_rvalid), 32'd0); advance();
    m_rvalid = 0; if_req = 1; if_addr = 32'h304;
    sample(); check("t4_regrant", 32'(if_gnt), 32'd1); advance();
    if_req = 0; m_gnt = 1; tick();
    m_gnt = 0; m_rvalid = 1; tick();
    m_rvalid = 0; tick();

    // Continuous contention from both requesters.
    do_reset();
    if_req = 1; if_addr = 32'h400;
    d_req = 1; d_we = 0; d_addr = 32'h80; d_type = TYPE_WORD;
    grants = 0; seq = '0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      m_gnt = busy && !accepted; m_rvalid = busy && accepted; m_rdata = $urandom;
      sample();
      if (win_valid) begin
        seq = {seq[2:0], d_gnt};
        grants++;
      end
      advance();
    end
`ifdef ARB_RR_EN
    seq_exp = 4'b1010;
`else
    seq_exp = 4'b1111;
`endif
    check("t5_grant_count", 32'(grants), 32'd4);
    check("t5_owner_seq", 32'(seq), 32'(seq_exp));
    if_req = 0; d_req = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      m_gnt = busy && !accepted; m_rvalid = busy && accepted;
      tick();
    end
    m_gnt = 0; m_rvalid = 0;

    // Random traffic, including stray m_gnt/m_rvalid in every state.
    for (int i = 0; i < 1500; i++) begin
      m_gnt    = ($urandom % 3) == 0;
      m_rvalid = !m_gnt && (($urandom % 3) == 0);
      m_rdata  = $urandom;
      sample();
      advance();
      if (if_req && win_valid && !win_data) if_req = 0;
      if (d_req && win_data) d_req = 0;
      if (!if_req && ($urandom % 3) == 0) begin
        if_req = 1; if_addr = $urandom & ~32'h3;
      end
      if (!d_req && ($urandom % 3) == 0) begin
        d_req = 1; d_we = $urandom % 2; d_type = 2'($urandom);
        d_sign_ext = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port data memory between instruction fetch and the execute-stage load/store path. It accepts one request at a time, holds the memory-side request until the memory accepts it, and routes the response back to the requester that owns the transaction. It sits between the fetch/execute stages and the memory backend. It is the structural step from split instruction/data memories to one unified memory.

## Interface
- DATA_WIDTH, 32, data and address width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  DATA_WIDTH  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid, one-cycle pulse
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_type  in  2  access size, same encoding as datamem type_control
- d_sign_ext  in  1  load sign-extend flag
- d_addr  in  DATA_WIDTH  load/store byte address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  load/store request accepted this cycle
- d_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse
- d_rdata  out  DATA_WIDTH  load data
- m_req  out  1  memory request, held until m_gnt
- m_we, m_type, m_sign_ext, m_addr, m_wdata  out  1/2/1/DATA_WIDTH/DATA_WIDTH  registered request fields
- m_gnt  in  1  memory accepted m_req
- m_rvalid  in  1  memory response; read data or write acknowledge
- m_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states:
  - IDLE: if any req, pick winner; assert winner's gnt combinationally; latch winner's fields into m_* registers and owner bit; go ISSUE. No req: stay.
  - ISSUE: m_req = 1. m_gnt = 1 -> WAIT.
  - WAIT: m_rvalid = 1 -> forward to owner (x_rvalid = 1, x_rdata = m_rdata, same cycle) -> IDLE.
- Fetch requests are always loads: m_we = 0, m_type = word, m_sign_ext = 0.
- One outstanding transaction; gnt never asserts outside IDLE; a requester not granted keeps req high.
- Fixed priority when both request in IDLE: data wins (older instruction).
- if_rdata/d_rdata are muxed from m_rdata. Non-owner rvalid is 0. rdata is don't-care while rvalid = 0.
- A store acknowledge pulses d_rvalid; d_rdata is don't-care.
- m_rvalid outside WAIT is ignored (spurious or stale response).
- m_gnt outside ISSUE is ignored.

## Timing
- Reset: state IDLE; all outputs 0; m_* registers 0; owner = fetch.
- Reset asserted mid-transaction: transaction is abandoned immediately and m_req drops asynchronously. Any late m_rvalid after reset release is discarded because the FSM is in IDLE.
- Minimum turnaround:
  - cycle 0: req, gnt
  - cycle 1: m_req, m_gnt
  - cycle 2: m_rvalid, x_rvalid
  - cycle 3: IDLE, next grant possible
- Memory must not assert m_rvalid in the same cycle as m_gnt.
- m_* fields are stable from ISSUE entry until return to IDLE.
- Back-to-back: a pending req is granted on the first IDLE cycle after the rvalid cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. A last-winner register is updated at each grant. On contention, the requester that did not win last is granted. Reset value is fetch, so data wins the first contention.
- ARB_RR_EN undefined: fixed data-over-fetch priority and no last-winner register. Fetch can starve under continuous data requests.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x100, m_gnt in cycle 1, m_rvalid + m_rdata = 0xDEADBEEF in cycle 2 -> if_gnt in cycle 0; m_addr = 0x100, m_we = 0; if_rvalid pulse with 0xDEADBEEF in cycle 2; d_rvalid stays 0.
- Store with memory stall: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0x12345678, d_type = word, m_gnt delayed 3 cycles -> m_req high 3 cycles with fields stable; d_rvalid pulses on m_rvalid.
- Contention: both req every cycle for 4 transactions -> without ARB_RR_EN, owner sequence D,D,D,D. With ARB_RR_EN, D,F,D,F.
- Spurious response: m_rvalid pulsed in IDLE and again in ISSUE -> no rvalid on either requester; FSM state unchanged.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> all outputs 0 immediately; m_rvalid arriving after release produces no rvalid; next if_req is granted normally.
